// File: rtl/mem_ctrl_if.sv
// Pipeline-side bundle of the memory control unit: the fetch byte port,
// the MEM-stage access port and the stall request towards ctrl.
interface mem_ctrl_if;
   // fetch port
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [7:0]  if_data_o;
   // MEM-stage port
   logic        mem_req_i;
   logic        mem_we_i;
   logic [1:0]  mem_len_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_done_o;
   // stall request to ctrl
   logic        stall_req_o;

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
      input  if_data_o, mem_rdata_o, mem_done_o, stall_req_o
   );

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
      output if_data_o, mem_rdata_o, mem_done_o, stall_req_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// Memory control unit: shares one byte-wide single-port RAM between the
// fetch port (pure passthrough) and the MEM-stage port, which is sequenced
// one byte per cycle by a small FSM. MEM always wins; fetch is stalled.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_ctrl_if.slave         bus,
   input  logic [7:0]        ram_din_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, LAST, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;       // byte index within the access
   logic [1:0]  last_q, last_d;     // index of the final byte (n-1)
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic        done_q, done_d;
   logic        stall;
   logic [31:0] byte_addr;
   logic [1:0]  prev_idx;

   assign byte_addr = addr_q + {30'd0, cnt_q};
   // read data lags its address by one cycle, so ACCESS captures the previous byte
   assign prev_idx  = cnt_q - 2'd1;

   assign bus.if_data_o   = ram_din_i;
   assign bus.mem_rdata_o = rdata_q;
   assign bus.mem_done_o  = done_q;
   assign bus.stall_req_o = stall;

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

   // next-state, RAM mux, byte sequencing and stall decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      we_d       = we_q;
      stall      = 1'b0;
      ram_addr_o = bus.if_req_i ? bus.if_addr_i[ADDR_W-1:0] : '0;
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'h00;

      case (state_q)
         IDLE: begin
            stall = bus.mem_req_i;
            if (bus.mem_req_i) begin
               addr_d  = bus.mem_addr_i;
               wdata_d = bus.mem_wdata_i;
               we_d    = bus.mem_we_i;
               cnt_d   = 2'd0;
               case (bus.mem_len_i)
                  2'b00:   last_d = 2'd0;
                  2'b01:   last_d = 2'd1;
                  default: last_d = 2'd3;
               endcase
               if (!bus.mem_we_i) begin
                  rdata_d = 32'd0;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            stall      = 1'b1;
            ram_addr_o = byte_addr[ADDR_W-1:0];
            ram_wr_o   = we_q;
            ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
            if (!we_q && (cnt_q != 2'd0)) begin
               rdata_d[{prev_idx, 3'b000} +: 8] = ram_din_i;
            end
            if (cnt_q == last_q) begin
               state_d = we_q ? DONE : LAST;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         LAST: begin
            stall      = 1'b1;
            ram_addr_o = addr_q[ADDR_W-1:0];
            rdata_d[{last_q, 3'b000} +: 8] = ram_din_i;
            state_d    = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed scenarios and randomized
// accesses checked against a transaction-level memory image.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ram_din;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;

   // RAM model controls used for preloading/clearing
   logic        clr;
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [7:0]  pre_data;
   logic [7:0]  tb_ram [0:4095];

   // reference image, written only by this bench's transaction model
   logic [7:0]  ref_mem [0:4095];
   logic [31:0] exp_rdata;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   mem_ctrl_if bus ();

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .ram_din_i  (ram_din),
      .ram_addr_o (ram_addr),
      .ram_wr_o   (ram_wr),
      .ram_dout_o (ram_dout)
   );

   always #5 clk = ~clk;

   // synchronous byte RAM, 1-cycle read latency, 4 KiB image
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 4096; i++) tb_ram[i] <= 8'h00;
      end else if (pre_we) begin
         tb_ram[pre_addr] <= pre_data;
      end else if (ram_wr) begin
         tb_ram[ram_addr[11:0]] <= ram_dout;
      end
      ram_din <= tb_ram[ram_addr[11:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a[11:0];
      pre_data = d;
      ref_mem[a[11:0]] = d;
      tick();
      pre_we = 1'b0;
   endtask

   // one MEM access; every cycle from accept (0) to completion is checked
   task automatic do_txn(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ifr, input logic [31:0] ifa);
      int n;
      int dc;
      logic [31:0] a;
      n  = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      dc = we ? n + 1 : n + 2;
      if (!we) begin
         exp_rdata = 32'd0;
         for (int k = 0; k < n; k++) begin
            a = addr + k;
            exp_rdata[8*k +: 8] = ref_mem[a[11:0]];
         end
      end
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
      bus.if_req_i    = ifr;
      bus.if_addr_i   = ifa;
      #1;
      for (int c = 0; c <= dc; c++) begin
         chk("stall", bus.stall_req_o, (c < dc) ? 1'b1 : 1'b0);
         chk("done", bus.mem_done_o, (c == dc) ? 1'b1 : 1'b0);
         chk("ram_wr", ram_wr, (we && c >= 1 && c <= n) ? 1'b1 : 1'b0);
         if (c >= 1 && c <= n) chk("ram_addr_acc", ram_addr, addr + (c - 1));
         if (c == 0 || c == dc) chk("ram_addr_fetch", ram_addr, ifr ? ifa : 32'd0);
         if (c == dc) begin
            chk("rdata", bus.mem_rdata_o, exp_rdata);
            bus.mem_req_i = 1'b0;
         end else begin
            @(posedge clk);
            #2;
         end
      end
      if (we) begin
         for (int k = 0; k < n; k++) begin
            a = addr + k;
            ref_mem[a[11:0]] = wdata[8*k +: 8];
         end
      end
      bus.if_req_i = 1'b0;
      $display("txn we=%0d len=%0d addr=%h wdata=%h rdata=%h", we, len, addr, wdata, bus.mem_rdata_o);
      tick();
   endtask

   task automatic fetch(input logic [31:0] a);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = a;
      #1;
      chk("fetch_addr", ram_addr, a);
      chk("fetch_wr", ram_wr, 1'b0);
      chk("fetch_stall", bus.stall_req_o, 1'b0);
      tick();
      chk("fetch_data", bus.if_data_o, ref_mem[a[11:0]]);
      $display("fetch addr=%h data=%h", a, bus.if_data_o);
      bus.if_req_i = 1'b0;
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rl;
      logic        rw;
      rst = 1'b1;
      clr = 1'b1;
      pre_we = 1'b0;
      pre_addr = 12'd0;
      pre_data = 8'd0;
      bus.if_req_i = 1'b0;
      bus.if_addr_i = 32'd0;
      bus.mem_req_i = 1'b0;
      bus.mem_we_i = 1'b0;
      bus.mem_len_i = 2'b00;
      bus.mem_addr_i = 32'd0;
      bus.mem_wdata_i = 32'd0;
      exp_rdata = 32'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      tick();
      clr = 1'b0;
      chk("rst_done", bus.mem_done_o, 1'b0);
      chk("rst_rdata", bus.mem_rdata_o, 32'd0);
      chk("rst_stall", bus.stall_req_o, 1'b0);
      chk("rst_wr", ram_wr, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      preload(32'h10, 8'hAB);
      preload(32'h100, 8'h11);
      preload(32'h101, 8'h22);
      preload(32'h102, 8'h33);
      preload(32'h103, 8'h44);
      preload(32'h201, 8'h5A);
      preload(32'hFFF, 8'hC1);
      preload(32'h000, 8'hD2);
      for (int i = 0; i < 4; i++) preload(32'h400 + i, 8'hA0 + 8'(i));

      // fetch passthrough
      fetch(32'h10);
      chk("fetch_ab", bus.if_data_o, 32'hAB);

      // word load
      do_txn(1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 32'h0);
      chk("word_load", bus.mem_rdata_o, 32'h44332211);

      // byte and halfword stores; a store leaves rdata alone
      do_txn(1'b1, 2'b00, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0);
      do_txn(1'b1, 2'b01, 32'h300, 32'hDEADBEEF, 1'b0, 32'h0);
      chk("st_200", tb_ram[12'h200], 32'hEF);
      chk("st_201", tb_ram[12'h201], 32'h5A);
      chk("st_300", tb_ram[12'h300], 32'hEF);
      chk("st_301", tb_ram[12'h301], 32'hBE);
      chk("rdata_hold", bus.mem_rdata_o, 32'h44332211);

      // halfword load across the 32-bit address wrap
      do_txn(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0);
      chk("wrap_load", bus.mem_rdata_o, 32'h0000D2C1);

      // fetch and MEM contending in the same cycle
      do_txn(1'b0, 2'b00, 32'h102, 32'h0, 1'b1, 32'h55);
      chk("cont_load", bus.mem_rdata_o, 32'h33);

      // reset in the middle of a word store
      bus.mem_req_i = 1'b1;
      bus.mem_we_i = 1'b1;
      bus.mem_len_i = 2'b10;
      bus.mem_addr_i = 32'h400;
      bus.mem_wdata_i = 32'h12345678;
      #1;
      chk("mr_stall0", bus.stall_req_o, 1'b1);
      tick();
      chk("mr_wr1", ram_wr, 1'b1);
      chk("mr_addr1", ram_addr, 32'h400);
      tick();
      chk("mr_wr2", ram_wr, 1'b1);
      chk("mr_addr2", ram_addr, 32'h401);
      rst = 1'b1;
      bus.mem_req_i = 1'b0;
      #1;
      chk("mr_wr_rst", ram_wr, 1'b0);
      chk("mr_stall_rst", bus.stall_req_o, 1'b0);
      chk("mr_rdata_rst", bus.mem_rdata_o, 32'd0);
      ref_mem[12'h400] = 8'h78;
      exp_rdata = 32'd0;
      for (int i = 0; i < 3; i++) begin
         chk("mr_done", bus.mem_done_o, 1'b0);
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mr_done_after", bus.mem_done_o, 1'b0);
         chk("mr_stall_after", bus.stall_req_o, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) chk("mr_ram", tb_ram[12'h400 + 12'(i)], ref_mem[12'h400 + 12'(i)]);
      $display("txn reset-cut word store addr=00000400");

      // randomized accesses in a private window, including len=11
      for (int i = 0; i < 40; i++) begin
         ra = 32'h800 + $urandom_range(0, 120);
         rl = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         do_txn(rw, rl, ra, $urandom, 1'($urandom_range(0, 1)), 32'h800 + $urandom_range(0, 127));
         fetch(32'h800 + $urandom_range(0, 127));
      end
      for (int i = 12'h800; i < 12'h900; i++) chk("window", tb_ram[i], ref_mem[i]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // hard time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
